baton_beat_detector: RTL and testbench
======================================

# baton_beat_detector

Parametrised successor to the single-axis baton derivative tracker. Takes the baton centre-of-mass coordinate from the camera pipeline on every `measure_in` strobe, finds turning points using a hysteresis deadband rather than a raw derivative sign flip, and enforces a refractory gap between beats. Emits a one-cycle beat pulse with beat type (top or bottom of stroke) and the cycle interval since the previous beat for the downstream tempo/MIDI logic.

## Interface
Parameters:
- `COORD_W`, 11: coordinate width, unsigned.
- `DEADBAND`, 8: reversal distance, in pixels, needed to declare a turning point.
- `MIN_GAP`, 100_000: minimum clock cycles between emitted beats.
- `INTERVAL_W`, 24: width of the interval counter and output.
- `LOG_DEPTH`, 2: log2 of the smoothing window length. Used only with `BATON_SMOOTH_EN`.

Ports:
- `clk_camera_in`, input, 1: sole clock.
- `rst_n_in`, input, 1: asynchronous, active-low reset.
- `coord_in`, input, `COORD_W`: centre-of-mass coordinate. Camera y increases downward.
- `measure_in`, input, 1: sample strobe. `coord_in` is valid when this is high.
- `beat_out`, output, 1: one-cycle pulse on an accepted turning point.
- `beat_bottom_out`, output, 1: type of the last emitted beat. 1 = bottom (downbeat/ictus, max y), 0 = top. Held between beats.
- `interval_out`, output, `INTERVAL_W`: cycles from the previous emitted beat to this one. Saturating. Updated with `beat_out`.
- `interval_valid_out`, output, 1: high once a second beat has been emitted. Cleared only by reset.

## Operation
- All outputs reset to 0. The state machine resets to `S_INIT`.
- The sample `s` is `coord_in`, or the filtered value when smoothing is enabled. It is processed only on cycles where `measure_in` is high (or the filter output strobe is high, when smoothing is enabled).
- Internal registers: extremum register `ext`, reference `ref`, state.

State machine:
- `S_INIT`: the first processed sample loads `ref` and `ext`.
  - If `s > ref + DEADBAND`, go to `S_DOWN` with `ext = s`.
  - If `s + DEADBAND < ref`, go to `S_UP` with `ext = s`.
  - No beat is produced in this state.
- `S_DOWN` (moving toward larger y):
  - If `s > ext`, then `ext <= s`.
  - Else if `s + DEADBAND < ext`, this is a bottom turning point: go to `S_UP` with `ext <= s`.
- `S_UP`: mirror of `S_DOWN`. Track the minimum. If `s > ext + DEADBAND`, this is a top turning point: go to `S_DOWN`.
- A reversal of exactly `DEADBAND` is not a turning point. Strict inequality is required.

Arithmetic:
- All comparisons are done at `COORD_W+1` bits, zero-extended, so `ext + DEADBAND` never wraps.

Refractory gap and beat emission:
- The gap counter increments every clock and saturates at `2^INTERVAL_W - 1`.
- A turning point is emitted only if this is the first beat since reset, or the counter is at least `MIN_GAP`.
- On emission:
  - `beat_out` = 1 for one cycle.
  - `beat_bottom_out` is set to the turning-point type.
  - `interval_out` = counter value, and the counter clears to 0 on the same edge.
  - `interval_valid_out` goes to 1 if this is not the first beat.
- If the gap is not met, the state still flips and `ext` still reloads. No pulse is produced, the outputs are unchanged and the counter is not cleared.
- Reset asserted mid-stroke returns the block to `S_INIT`, clears the counter and clears the first-beat flag. Any pending beat is discarded.

## Timing
- Without smoothing: sample accepted at edge N, `beat_out` high during cycle N+1. Latency is 1 cycle.
- With smoothing: latency is 2 cycles (one filter register stage).
- `measure_in` may be high on consecutive cycles. The block sustains one sample per clock.
- Back-to-back beats are impossible, because `MIN_GAP` ≥ 1 is required.
- Counter saturation: an interval of at least `2^INTERVAL_W - 1` is reported as all-ones.

## Configuration
- `BATON_SMOOTH_EN` defined:
  - Samples pass through a boxcar average of the last `2^LOG_DEPTH` accepted samples, output as `sum >> LOG_DEPTH`.
  - The sum is `COORD_W+LOG_DEPTH` bits.
  - `S_INIT` ignores filter output until `2^LOG_DEPTH` samples have been accepted since reset.
- `BATON_SMOOTH_EN` undefined: `coord_in` feeds the state machine directly and `LOG_DEPTH` is unused.

## Structure
- Package `baton_pkg`: state enum (`S_INIT`, `S_DOWN`, `S_UP`), a beat-type localparam (`BEAT_TOP` = 0, `BEAT_BOTTOM` = 1), and the default `DEADBAND` and `MIN_GAP` constants.
- One sub-module, `com_moving_average`: shift register plus running sum, with valid in and valid out. It is instantiated only under `BATON_SMOOTH_EN`.

## Test plan
- **Basic down-then-up stroke.** Reset, `DEADBAND` = 8, `MIN_GAP` = 10. Ramp y from 100 to 200 in steps of 5, then to 150. Expect:
  - one `beat_out` when y = 190 is sampled (first sample with `s + 8 < 200`);
  - `beat_bottom_out` = 1;
  - `interval_valid_out` = 0.
- **Deadband noise.** Oscillate ±4 around 300 for 1000 samples. Expect no `beat_out`, and the state stays in `S_INIT` (not `S_DOWN`/`S_UP`).
- **Refractory suppression.** Top and bottom reversals of 20 px, 5 cycles apart, with `MIN_GAP` = 50. Expect only the first reversal pulses. The next reversal after 50 cycles pulses with `interval_out` ≥ 50.
- **Interval and saturation.** Two beats 1234 cycles apart: expect `interval_out` = 1234 and `interval_valid_out` = 1. With `INTERVAL_W` = 8 and 300 cycles apart: expect `interval_out` = 255.
- **Reset mid-stroke.** Drive y 0 → 100, then pulse `rst_n_in` low asynchronously (not on a clock edge). Expect all outputs 0 immediately and the state back in `S_INIT`. The next reversal produces no beat until a new direction is established.
- **Smoothing on.** With `BATON_SMOOTH_EN` and `LOG_DEPTH` = 2, single-sample spikes of +40 must not produce a beat. Beat latency must be 2 cycles.

Source files
------------

// File: rtl/baton_pkg.sv
// ---------------------------------------------------------------------------
// baton_pkg
//
// Shared definitions for the baton beat detector:
//   - state encoding for the turning-point state machine (S_INIT/S_DOWN/S_UP)
//   - beat type encoding (BEAT_TOP / BEAT_BOTTOM)
//   - default reversal deadband and refractory gap
// ---------------------------------------------------------------------------
package baton_pkg;

  // State machine encoding, kept as plain constants so older tools and
  // waveform scripts that expect numeric state codes keep working.
  typedef logic [1:0] state_t;

  localparam state_t S_INIT = 2'd0;
  localparam state_t S_DOWN = 2'd1;
  localparam state_t S_UP   = 2'd2;

  // Beat type as reported on beat_bottom_out.
  localparam logic BEAT_TOP    = 1'b0;
  localparam logic BEAT_BOTTOM = 1'b1;

  // Defaults: 8 px of reversal and 100k cycles between beats.
  localparam int BATON_DEADBAND = 8;
  localparam int BATON_MIN_GAP  = 100_000;

endpackage

// File: rtl/com_moving_average.sv
// ---------------------------------------------------------------------------
// com_moving_average
//
// Boxcar average of the last 2**LOG_DEPTH accepted centre-of-mass samples.
// A shift register holds the window and a running sum is updated by adding
// the new sample and subtracting the one falling out of the window. The
// output strobe only starts once the window has been completely filled
// since reset, so the consumer never sees a partially averaged value.
//
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   data_in   : sample, DATA_W bits unsigned
//   valid_in  : data_in is valid this cycle
//   data_out  : window average (sum >> LOG_DEPTH), DATA_W bits
//   valid_out : data_out is valid this cycle (one cycle after valid_in)
// ---------------------------------------------------------------------------
module com_moving_average
  import baton_pkg::*;
#(
  parameter int DATA_W    = 11,
  parameter int LOG_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int SUM_W = DATA_W + LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_V = (LOG_DEPTH + 1)'(DEPTH);

  logic [DATA_W-1:0]  window [DEPTH];
  logic [SUM_W-1:0]   sum;
  logic [LOG_DEPTH:0] fill;
  logic               full;
  logic               valid_q;

  assign full = (fill == DEPTH_V);

  // Window shift and running sum. The window resets to zero, so the sum is
  // exact even while the window is still filling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        window[i] <= '0;
      end
      sum     <= '0;
      fill    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in && (full || (fill == DEPTH_V - 1'b1));
      if (valid_in) begin
        window[0] <= data_in;
        for (int i = 1; i < DEPTH; i++) begin
          window[i] <= window[i-1];
        end
        sum <= sum + SUM_W'(data_in) - SUM_W'(window[DEPTH-1]);
        if (!full) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  assign data_out  = sum[SUM_W-1:LOG_DEPTH];
  assign valid_out = valid_q;

endmodule

// File: rtl/baton_beat_detector.sv
// ---------------------------------------------------------------------------
// baton_beat_detector
//
// Finds turning points of the baton's vertical centre of mass using a
// hysteresis deadband and emits a one-cycle beat pulse, the beat type and
// the interval since the previous beat. A refractory gap suppresses beats
// that come too soon after the previous one.
//
// Optional feature: define BATON_SMOOTH_EN to pass samples through a
// 2**LOG_DEPTH boxcar average (com_moving_average) before the state machine.
//
// Ports:
//   clk_camera_in      : sole clock
//   rst_n_in           : asynchronous active-low reset
//   coord_in           : centre-of-mass y coordinate (grows downward)
//   measure_in         : coord_in valid strobe
//   beat_out           : one-cycle pulse on an accepted turning point
//   beat_bottom_out    : type of last beat, 1 = bottom (max y), 0 = top
//   interval_out       : cycles since previous beat, saturating
//   interval_valid_out : set once a second beat has been emitted
// ---------------------------------------------------------------------------
module baton_beat_detector
  import baton_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int DEADBAND   = BATON_DEADBAND,
  parameter int MIN_GAP    = BATON_MIN_GAP,
  parameter int INTERVAL_W = 24,
  parameter int LOG_DEPTH  = 2
) (
  input  logic                  clk_camera_in,
  input  logic                  rst_n_in,
  input  logic [COORD_W-1:0]    coord_in,
  input  logic                  measure_in,
  output logic                  beat_out,
  output logic                  beat_bottom_out,
  output logic [INTERVAL_W-1:0] interval_out,
  output logic                  interval_valid_out
);

  // Elaboration-time sanity check: a zero gap would allow back-to-back beats.
  if (MIN_GAP < 1 || DEADBAND < 0 || LOG_DEPTH < 0) begin : g_param_check
    $error("baton_beat_detector: MIN_GAP must be >= 1, DEADBAND and LOG_DEPTH >= 0");
  end

  // One extra bit so that ext + DEADBAND can never wrap.
  localparam logic [COORD_W:0] DB = (COORD_W + 1)'(DEADBAND);

  // Gap comparison width wide enough for both the counter and MIN_GAP.
  localparam int CMP_W = (INTERVAL_W > 32) ? INTERVAL_W + 1 : 33;

  logic [COORD_W-1:0] sample;
  logic               sample_valid;

`ifdef BATON_SMOOTH_EN
  com_moving_average #(
    .DATA_W    (COORD_W),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_smooth (
    .clk       (clk_camera_in),
    .rst_n     (rst_n_in),
    .data_in   (coord_in),
    .valid_in  (measure_in),
    .data_out  (sample),
    .valid_out (sample_valid)
  );
`else
  assign sample       = coord_in;
  assign sample_valid = measure_in;
`endif

  state_t             state, state_next;
  logic [COORD_W-1:0] ext_coord, ext_next;
  logic [COORD_W-1:0] ref_coord, ref_next;
  logic               ref_loaded, ref_loaded_next;
  logic               turn;
  logic               turn_bottom;

  logic [INTERVAL_W-1:0] gap_count;
  logic                  gap_sat;
  logic                  gap_met;
  logic                  beat_seen;
  logic                  emit;

  logic [COORD_W:0] s_x, ext_x, ref_x;

  assign s_x   = {1'b0, sample};
  assign ext_x = {1'b0, ext_coord};
  assign ref_x = {1'b0, ref_coord};

  // Turning-point detection. S_INIT first captures a reference, then waits
  // for a move beyond the deadband to learn the initial direction. S_DOWN
  // tracks the running maximum and S_UP the running minimum; a retreat of
  // strictly more than DEADBAND from the extremum is a turning point.
  always_comb begin
    state_next      = state;
    ext_next        = ext_coord;
    ref_next        = ref_coord;
    ref_loaded_next = ref_loaded;
    turn            = 1'b0;
    turn_bottom     = BEAT_TOP;
    if (sample_valid) begin
      case (state)
        S_INIT: begin
          if (!ref_loaded) begin
            ref_next        = sample;
            ext_next        = sample;
            ref_loaded_next = 1'b1;
          end else if (s_x > ref_x + DB) begin
            state_next = S_DOWN;
            ext_next   = sample;
          end else if (s_x + DB < ref_x) begin
            state_next = S_UP;
            ext_next   = sample;
          end
        end
        S_DOWN: begin
          if (s_x > ext_x) begin
            ext_next = sample;
          end else if (s_x + DB < ext_x) begin
            turn        = 1'b1;
            turn_bottom = BEAT_BOTTOM;
            state_next  = S_UP;
            ext_next    = sample;
          end
        end
        S_UP: begin
          if (s_x < ext_x) begin
            ext_next = sample;
          end else if (s_x > ext_x + DB) begin
            turn        = 1'b1;
            turn_bottom = BEAT_TOP;
            state_next  = S_DOWN;
            ext_next    = sample;
          end
        end
        default: begin
          state_next = S_INIT;
        end
      endcase
    end
  end

  // The very first beat after reset has no previous beat to be too close to,
  // so it bypasses the refractory check.
  assign gap_sat = &gap_count;
  assign gap_met = !beat_seen || (CMP_W'(gap_count) >= CMP_W'(MIN_GAP));
  assign emit    = turn && gap_met;

  // State, extremum and reference registers.
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= S_INIT;
      ext_coord  <= '0;
      ref_coord  <= '0;
      ref_loaded <= 1'b0;
    end else begin
      state      <= state_next;
      ext_coord  <= ext_next;
      ref_coord  <= ref_next;
      ref_loaded <= ref_loaded_next;
    end
  end

  // Gap counter and beat outputs. A suppressed turning point leaves the
  // outputs and the counter alone; only an emitted beat restarts the count.
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gap_count          <= '0;
      beat_seen          <= 1'b0;
      beat_out           <= 1'b0;
      beat_bottom_out    <= 1'b0;
      interval_out       <= '0;
      interval_valid_out <= 1'b0;
    end else begin
      beat_out <= emit;
      if (emit) begin
        gap_count       <= '0;
        interval_out    <= gap_count;
        beat_bottom_out <= turn_bottom;
        beat_seen       <= 1'b1;
        if (beat_seen) begin
          interval_valid_out <= 1'b1;
        end
      end else if (!gap_sat) begin
        gap_count <= gap_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baton_beat_detector.sv
// ---------------------------------------------------------------------------
// tb_baton_beat_detector
//
// Directed bench for baton_beat_detector. Two instances share the stimulus:
//   dut_a : DEADBAND 8, MIN_GAP 50, INTERVAL_W 24
//   dut_b : DEADBAND 8, MIN_GAP 10, INTERVAL_W 8 (shows interval saturation)
// The default build exercises the unsmoothed path; with BATON_SMOOTH_EN the
// bench checks the filtered path and its two-cycle beat latency instead.
// ---------------------------------------------------------------------------
module tb_baton_beat_detector;
  import baton_pkg::*;

  localparam int COORD_W = 11;

  logic               clk_camera_in;
  logic               rst_n_in;
  logic [COORD_W-1:0] coord_in;
  logic               measure_in;

  logic        beat_a, bottom_a, valid_a;
  logic [23:0] interval_a;
  logic        beat_b, bottom_b, valid_b;
  logic [7:0]  interval_b;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    logic [COORD_W-1:0] coord;
    logic               measure;
    logic               expBeat;
    logic               expBottom;
    logic               expValid;
  } vec_t;

  vec_t strokeVec[$];

  baton_beat_detector #(
    .COORD_W(COORD_W), .DEADBAND(8), .MIN_GAP(50), .INTERVAL_W(24), .LOG_DEPTH(2)
  ) dut_a (
    .clk_camera_in      (clk_camera_in),
    .rst_n_in           (rst_n_in),
    .coord_in           (coord_in),
    .measure_in         (measure_in),
    .beat_out           (beat_a),
    .beat_bottom_out    (bottom_a),
    .interval_out       (interval_a),
    .interval_valid_out (valid_a)
  );

  baton_beat_detector #(
    .COORD_W(COORD_W), .DEADBAND(8), .MIN_GAP(10), .INTERVAL_W(8), .LOG_DEPTH(2)
  ) dut_b (
    .clk_camera_in      (clk_camera_in),
    .rst_n_in           (rst_n_in),
    .coord_in           (coord_in),
    .measure_in         (measure_in),
    .beat_out           (beat_b),
    .beat_bottom_out    (bottom_b),
    .interval_out       (interval_b),
    .interval_valid_out (valid_b)
  );

  // 10-unit clock period.
  initial begin
    clk_camera_in = 1'b0;
    forever #5 clk_camera_in = ~clk_camera_in;
  end

  // One comparison: counts it and reports a miscompare with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one clock of input (changed at the falling edge) and returns 1
  // unit after the following rising edge, where outputs are sampled.
  task automatic applyStimulus(input logic [COORD_W-1:0] coord, input logic measure);
    @(negedge clk_camera_in);
    coord_in   = coord;
    measure_in = measure;
    @(posedge clk_camera_in);
    #1;
    measure_in = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(11'd0, 1'b0);
    end
  endtask

  // Reset asserted away from the clock edge, outputs checked while it is held.
  task automatic pulseReset(input bit check);
    @(posedge clk_camera_in);
    #3 rst_n_in = 1'b0;
    #1;
    if (check) begin
      checkOutput("async reset beat", beat_a, 0);
      checkOutput("async reset bottom", bottom_a, 0);
      checkOutput("async reset interval", interval_a, 0);
      checkOutput("async reset valid", valid_a, 0);
      checkOutput("async reset state", dut_a.state, S_INIT);
      checkOutput("async reset b interval", interval_b, 0);
    end
    @(posedge clk_camera_in);
    @(posedge clk_camera_in);
    #3 rst_n_in = 1'b1;
  endtask

  initial begin
    int noiseBeats;
    rst_n_in   = 1'b0;
    coord_in   = '0;
    measure_in = 1'b0;
    #12;
    // Everything is zero while reset is held from time 0.
    checkOutput("reset beat", beat_a, 0);
    checkOutput("reset bottom", bottom_a, 0);
    checkOutput("reset interval", interval_a, 0);
    checkOutput("reset valid", valid_a, 0);
    checkOutput("reset state", dut_a.state, S_INIT);
    #11 rst_n_in = 1'b1;

`ifdef BATON_SMOOTH_EN
    // Window fills with 100, then rises to 200 (averages 125..200 move the
    // machine to S_DOWN). A drop to 0 averages to 150, a bottom turning point
    // processed one cycle after the sample and visible one cycle after that.
    for (int i = 0; i < 8; i++) applyStimulus(11'd100, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(11'd200, 1'b1);
    checkOutput("smooth state down", dut_a.state, S_DOWN);
    checkOutput("smooth no early beat", beat_a, 0);
    applyStimulus(11'd0, 1'b1);
    checkOutput("smooth latency cycle 1", beat_a, 0);
    applyStimulus(11'd0, 1'b0);
    checkOutput("smooth latency cycle 2", beat_a, 1);
    checkOutput("smooth bottom", bottom_a, 1);
    checkOutput("smooth valid", valid_a, 0);
`else
    // Down stroke 100..200 then back to 150. A measure-low cycle carrying a
    // bogus 900 must be ignored, otherwise the bottom would fire too early.
    for (int y = 100; y <= 200; y += 5) begin
      strokeVec.push_back('{11'(y), 1'b1, 1'b0, 1'b0, 1'b0});
      if (y == 150) strokeVec.push_back('{11'd900, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    strokeVec.push_back('{11'd195, 1'b1, 1'b0, 1'b0, 1'b0});
    strokeVec.push_back('{11'd190, 1'b1, 1'b1, 1'b1, 1'b0});
    for (int y = 185; y >= 150; y -= 5) begin
      strokeVec.push_back('{11'(y), 1'b1, 1'b0, 1'b1, 1'b0});
    end

    foreach (strokeVec[i]) begin
      applyStimulus(strokeVec[i].coord, strokeVec[i].measure);
      checkOutput($sformatf("stroke[%0d] beat", i), beat_a, strokeVec[i].expBeat);
      checkOutput($sformatf("stroke[%0d] bottom", i), bottom_a, strokeVec[i].expBottom);
      checkOutput($sformatf("stroke[%0d] valid", i), valid_a, strokeVec[i].expValid);
      checkOutput($sformatf("stroke[%0d] b beat", i), beat_b, strokeVec[i].expBeat);
    end

    // Top turning point 108 counter ticks after the bottom beat.
    idleCycles(100);
    applyStimulus(11'd170, 1'b1);
    checkOutput("top beat", beat_a, 1);
    checkOutput("top type", bottom_a, 0);
    checkOutput("top interval", interval_a, 108);
    checkOutput("top valid", valid_a, 1);
    checkOutput("top b interval", interval_b, 108);

    // 20 px reversals a few cycles later are inside both refractory gaps.
    applyStimulus(11'd150, 1'b1);
    checkOutput("refractory 1 beat", beat_a, 0);
    checkOutput("refractory 1 b beat", beat_b, 0);
    idleCycles(3);
    applyStimulus(11'd175, 1'b1);
    checkOutput("refractory 2 beat", beat_a, 0);
    checkOutput("refractory 2 interval", interval_a, 108);
    checkOutput("refractory 2 state", dut_a.state, S_DOWN);
    idleCycles(60);
    applyStimulus(11'd150, 1'b1);
    checkOutput("post gap beat", beat_a, 1);
    checkOutput("post gap bottom", bottom_a, 1);
    checkOutput("post gap interval", interval_a, 65);

    // Long intervals: dut_b's 8-bit interval saturates at 255.
    idleCycles(1234);
    applyStimulus(11'd170, 1'b1);
    checkOutput("interval 1234 beat", beat_a, 1);
    checkOutput("interval 1234", interval_a, 1234);
    checkOutput("interval 1234 b sat", interval_b, 255);
    idleCycles(300);
    applyStimulus(11'd150, 1'b1);
    checkOutput("interval 300", interval_a, 300);
    checkOutput("interval 300 b sat", interval_b, 255);
    checkOutput("interval 300 b valid", valid_b, 1);

    // +/-4 around 300 never leaves the deadband.
    pulseReset(1'b0);
    noiseBeats = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus((i == 0) ? 11'd300 : ((i % 2) ? 11'd296 : 11'd304), 1'b1);
      if (beat_a !== 1'b0) noiseBeats++;
    end
    checkOutput("noise beats", noiseBeats, 0);
    checkOutput("noise state", dut_a.state, S_INIT);

    // From reference 300: 0 sets S_UP, 10 is the first (ungated) top beat,
    // the climb to 100 then a drop to 80 gives a gated bottom beat.
    applyStimulus(11'd0, 1'b1);
    applyStimulus(11'd10, 1'b1);
    checkOutput("first after reset beat", beat_a, 1);
    checkOutput("first after reset valid", valid_a, 0);
    for (int y = 20; y <= 100; y += 10) applyStimulus(11'(y), 1'b1);
    idleCycles(60);
    applyStimulus(11'd80, 1'b1);
    checkOutput("second after reset beat", beat_a, 1);
    checkOutput("second after reset interval", interval_a, 69);
    checkOutput("second after reset valid", valid_a, 1);
    applyStimulus(11'd90, 1'b1);
    applyStimulus(11'd100, 1'b1);

    // Mid-stroke reset: outputs clear at once, direction must be relearned.
    pulseReset(1'b1);
    applyStimulus(11'd80, 1'b1);
    applyStimulus(11'd88, 1'b1);
    checkOutput("init exact up", dut_a.state, S_INIT);
    applyStimulus(11'd72, 1'b1);
    checkOutput("init exact down", dut_a.state, S_INIT);
    applyStimulus(11'd60, 1'b1);
    checkOutput("init to up", dut_a.state, S_UP);
    checkOutput("init to up beat", beat_a, 0);
    applyStimulus(11'd75, 1'b1);
    checkOutput("relearn beat", beat_a, 1);
    checkOutput("relearn type", bottom_a, 0);
    checkOutput("relearn interval", interval_a, 4);
    checkOutput("relearn valid", valid_a, 0);

    // Retreat of exactly DEADBAND is not a turning point; one more pixel is.
    idleCycles(60);
    applyStimulus(11'd67, 1'b1);
    checkOutput("exact deadband beat", beat_a, 0);
    checkOutput("exact deadband state", dut_a.state, S_DOWN);
    applyStimulus(11'd66, 1'b1);
    checkOutput("deadband+1 beat", beat_a, 1);
    checkOutput("deadband+1 bottom", bottom_a, 1);
    checkOutput("deadband+1 interval", interval_a, 61);
    checkOutput("deadband+1 valid", valid_a, 1);
    applyStimulus(11'd66, 1'b0);
    checkOutput("beat one cycle", beat_a, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
